// File: rtl/hazard_ctrl_unit.sv
// Pipeline hazard/exception control for the 5-stage MIPS core: PC-source select,
// per-stage stall/flush, load-use bubbles, masked IRQ latch and trap/ERET sequencing.
module hazard_ctrl_unit #(
   parameter int              PC_W       = 32,
   parameter int              N_IRQ      = 4,
   parameter int              LOAD_LAT   = 1,
   parameter logic [PC_W-1:0] EXC_VECTOR = 32'h0000_0020
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              mem_stall,
   input  logic [4:0]        ifid_rs_addr,
   input  logic [4:0]        ifid_rt_addr,
   input  logic [4:0]        idex_rd_addr,
   input  logic              idex_mem_read,
   input  logic              exmem_branch_valid,
   input  logic [PC_W-1:0]   predicted_idex_pc,
   input  logic [PC_W-1:0]   target_exmem_pc,
   input  logic [PC_W-1:0]   exmem_pc,
   input  logic              id_jump,
   input  logic              exmem_syscall,
   input  logic              exmem_eret,
   input  logic [N_IRQ-1:0]  irq,
   input  logic [N_IRQ-1:0]  irq_mask,
   input  logic              int_enable,
   input  logic [PC_W-1:0]   cp0_epc,
   output logic [2:0]        cu_pc_src,
   output logic              cu_pc_stall,
   output logic              cu_ifid_stall,
   output logic              cu_idex_stall,
   output logic              cu_exmem_stall,
   output logic              cu_ifid_flush,
   output logic              cu_idex_flush,
   output logic              cu_exmem_flush,
   output logic              cu_cp0_w_en,
   output logic [4:0]        cu_exec_code,
   output logic [PC_W-1:0]   cu_epc,
   output logic [PC_W-1:0]   cu_vector,
   output logic              bpu_write_en,
   output logic [N_IRQ-1:0]  cu_irq_ack,
   output logic              cu_busy,
   output logic [1:0]        dbg_state
);

   typedef enum logic [1:0] {S_RUN, S_DRAIN, S_TRAP, S_ERET} state_t;

   localparam int         CNT_W   = (LOAD_LAT > 1) ? $clog2(LOAD_LAT) : 1;
   localparam logic [4:0] EXC_INT = 5'd0;
   localparam logic [4:0] EXC_SYS = 5'd8;

   state_t            r_state;
   logic [CNT_W-1:0]  r_lu_cnt;
   logic [N_IRQ-1:0]  r_irq_pend;
   logic [N_IRQ-1:0]  r_irq_line;
   logic [N_IRQ-1:0]  r_irq_ack;
   logic              r_cp0_w_en;
   logic [4:0]        r_exec_code;
   logic [PC_W-1:0]   r_epc;
   logic              r_busy;

   logic              w_irq_req;
   logic [N_IRQ-1:0]  w_irq_onehot;
   logic [N_IRQ-1:0]  w_trap_line;
   logic              w_trap;
   logic              w_mispredict;
   logic              w_lu_hazard;
   logic              w_lu_active;
   logic [CNT_W-1:0]  w_lu_reload;

   // Two's-complement trick isolates the lowest set pending bit (index 0 = highest priority).
   assign w_irq_onehot = r_irq_pend & (~r_irq_pend + N_IRQ'(1));
   assign w_irq_req    = int_enable && (|r_irq_pend);
   assign w_trap       = exmem_syscall || w_irq_req;
   assign w_trap_line  = exmem_syscall ? '0 : w_irq_onehot;
   assign w_mispredict = exmem_branch_valid && (predicted_idex_pc != target_exmem_pc);
   assign w_lu_hazard  = (LOAD_LAT != 0) && idex_mem_read && (idex_rd_addr != 5'd0) &&
                         ((idex_rd_addr == ifid_rs_addr) || (idex_rd_addr == ifid_rt_addr));
   assign w_lu_active  = (r_lu_cnt != '0) || w_lu_hazard;
   assign w_lu_reload  = CNT_W'(LOAD_LAT - 1);

   always_comb begin
      cu_pc_src      = 3'd0;
      cu_pc_stall    = 1'b0;
      cu_ifid_stall  = 1'b0;
      cu_idex_stall  = 1'b0;
      cu_exmem_stall = 1'b0;
      cu_ifid_flush  = 1'b0;
      cu_idex_flush  = 1'b0;
      cu_exmem_flush = 1'b0;
      bpu_write_en   = 1'b0;
      case (r_state)
         S_RUN: begin
            bpu_write_en = exmem_branch_valid && !mem_stall && !w_trap && !exmem_eret;
            if (w_trap || mem_stall || exmem_eret) begin
               cu_pc_stall    = 1'b1;
               cu_ifid_stall  = 1'b1;
               cu_idex_stall  = 1'b1;
               cu_exmem_stall = 1'b1;
            end else if (w_mispredict) begin
               cu_pc_src     = 3'd2;
               cu_ifid_flush = 1'b1;
               cu_idex_flush = 1'b1;
            end else if (id_jump) begin
               cu_pc_src     = 3'd1;
               cu_ifid_flush = 1'b1;
            end else if (w_lu_active) begin
               cu_pc_stall   = 1'b1;
               cu_ifid_stall = 1'b1;
               cu_idex_flush = 1'b1;
            end
         end
         S_DRAIN: begin
            cu_pc_stall    = 1'b1;
            cu_ifid_stall  = 1'b1;
            cu_idex_stall  = 1'b1;
            cu_exmem_stall = 1'b1;
         end
         S_TRAP: begin
            cu_pc_src      = 3'd3;
            cu_ifid_flush  = 1'b1;
            cu_idex_flush  = 1'b1;
            cu_exmem_flush = 1'b1;
         end
         default: begin
            cu_pc_src      = 3'd4;
            cu_ifid_flush  = 1'b1;
            cu_idex_flush  = 1'b1;
            cu_exmem_flush = 1'b1;
         end
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         r_state     <= S_RUN;
         r_lu_cnt    <= '0;
         r_irq_pend  <= '0;
         r_irq_line  <= '0;
         r_irq_ack   <= '0;
         r_cp0_w_en  <= 1'b0;
         r_exec_code <= '0;
         r_epc       <= '0;
         r_busy      <= 1'b0;
      end else begin
         r_irq_pend <= (r_irq_pend | (irq & irq_mask)) & ~r_irq_ack;
         r_irq_ack  <= '0;
         r_cp0_w_en <= 1'b0;
         case (r_state)
            S_RUN: begin
               if (w_trap) begin
                  r_exec_code <= exmem_syscall ? EXC_SYS : EXC_INT;
                  r_epc       <= exmem_pc;
                  r_irq_line  <= w_trap_line;
                  r_busy      <= 1'b1;
                  if (mem_stall) begin
                     r_state <= S_DRAIN;
                  end else begin
                     r_state    <= S_TRAP;
                     r_cp0_w_en <= 1'b1;
                     r_irq_ack  <= w_trap_line;
                  end
               end else if (!mem_stall) begin
                  if (exmem_eret) begin
                     r_state <= S_ERET;
                     r_busy  <= 1'b1;
                  end else if (w_mispredict) begin
                     r_lu_cnt <= '0;
                  end else if (!id_jump) begin
                     // A jump preempts the bubble for one cycle; the count resumes afterwards.
                     if (r_lu_cnt != '0)
                        r_lu_cnt <= r_lu_cnt - CNT_W'(1);
                     else if (w_lu_hazard)
                        r_lu_cnt <= w_lu_reload;
                  end
               end
            end
            S_DRAIN: begin
               if (!mem_stall) begin
                  r_state    <= S_TRAP;
                  r_cp0_w_en <= 1'b1;
                  r_irq_ack  <= r_irq_line;
               end
            end
            default: begin
               // TRAP and ERET flush ID/EX, so any outstanding bubble is moot.
               r_state  <= S_RUN;
               r_busy   <= 1'b0;
               r_lu_cnt <= '0;
            end
         endcase
      end
   end

   assign cu_cp0_w_en  = r_cp0_w_en;
   assign cu_exec_code = r_exec_code;
   assign cu_epc       = r_epc;
   assign cu_irq_ack   = r_irq_ack;
   assign cu_busy      = r_busy;
   assign cu_vector    = (r_state == S_ERET) ? cp0_epc : EXC_VECTOR;
   assign dbg_state    = r_state;

endmodule

// File: tb/tb_hazard_ctrl_unit.sv
// Bench for hazard_ctrl_unit: directed scenarios plus randomized traffic, all checked
// against a cycle-level behavioural model of the control rules.
module tb_hazard_ctrl_unit;

   localparam int          PC_W     = 32;
   localparam int          N_IRQ    = 4;
   localparam int          LOAD_LAT = 2;
   localparam logic [31:0] EXC_VEC  = 32'h0000_0020;

   logic              clk = 1'b0;
   logic              reset;
   logic              mem_stall;
   logic [4:0]        ifid_rs_addr, ifid_rt_addr, idex_rd_addr;
   logic              idex_mem_read;
   logic              exmem_branch_valid;
   logic [PC_W-1:0]   predicted_idex_pc, target_exmem_pc, exmem_pc, cp0_epc;
   logic              id_jump, exmem_syscall, exmem_eret;
   logic [N_IRQ-1:0]  irq, irq_mask;
   logic              int_enable;
   logic [2:0]        cu_pc_src;
   logic              cu_pc_stall, cu_ifid_stall, cu_idex_stall, cu_exmem_stall;
   logic              cu_ifid_flush, cu_idex_flush, cu_exmem_flush;
   logic              cu_cp0_w_en;
   logic [4:0]        cu_exec_code;
   logic [PC_W-1:0]   cu_epc, cu_vector;
   logic              bpu_write_en;
   logic [N_IRQ-1:0]  cu_irq_ack;
   logic              cu_busy;
   logic [1:0]        dbg_state;

   hazard_ctrl_unit #(
      .PC_W(PC_W), .N_IRQ(N_IRQ), .LOAD_LAT(LOAD_LAT), .EXC_VECTOR(EXC_VEC)
   ) dut (
      .clk(clk), .reset(reset), .mem_stall(mem_stall),
      .ifid_rs_addr(ifid_rs_addr), .ifid_rt_addr(ifid_rt_addr), .idex_rd_addr(idex_rd_addr),
      .idex_mem_read(idex_mem_read), .exmem_branch_valid(exmem_branch_valid),
      .predicted_idex_pc(predicted_idex_pc), .target_exmem_pc(target_exmem_pc),
      .exmem_pc(exmem_pc), .id_jump(id_jump), .exmem_syscall(exmem_syscall),
      .exmem_eret(exmem_eret), .irq(irq), .irq_mask(irq_mask), .int_enable(int_enable),
      .cp0_epc(cp0_epc), .cu_pc_src(cu_pc_src), .cu_pc_stall(cu_pc_stall),
      .cu_ifid_stall(cu_ifid_stall), .cu_idex_stall(cu_idex_stall),
      .cu_exmem_stall(cu_exmem_stall), .cu_ifid_flush(cu_ifid_flush),
      .cu_idex_flush(cu_idex_flush), .cu_exmem_flush(cu_exmem_flush),
      .cu_cp0_w_en(cu_cp0_w_en), .cu_exec_code(cu_exec_code), .cu_epc(cu_epc),
      .cu_vector(cu_vector), .bpu_write_en(bpu_write_en), .cu_irq_ack(cu_irq_ack),
      .cu_busy(cu_busy), .dbg_state(dbg_state)
   );

   always #5 clk = ~clk;

   int n_checks = 0;
   int n_fail   = 0;

   // reference model: what the pipeline is doing this cycle
   logic        m_wait, m_trap, m_ret;
   logic [4:0]  m_code;
   logic [31:0] m_epc;
   logic [3:0]  m_line, m_pend;
   int          m_bub;

   task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_checks++;
      if (obs !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, obs, exp, $time);
      end
   endtask

   function automatic logic [3:0] lowest(input logic [3:0] v);
      logic [3:0] r;
      r = 4'h0;
      for (int i = 3; i >= 0; i--) if (v[i]) r = 4'h1 << i;
      return r;
   endfunction

   task automatic clear_inputs();
      mem_stall = 0; ifid_rs_addr = 0; ifid_rt_addr = 0; idex_rd_addr = 0;
      idex_mem_read = 0; exmem_branch_valid = 0; predicted_idex_pc = 0;
      target_exmem_pc = 0; exmem_pc = 0; id_jump = 0; exmem_syscall = 0;
      exmem_eret = 0; irq = 0; irq_mask = 0; int_enable = 0; cp0_epc = 0;
   endtask

   task automatic model_clear();
      m_wait = 0; m_trap = 0; m_ret = 0; m_code = 0; m_epc = 0;
      m_line = 0; m_pend = 0; m_bub = 0;
   endtask

   task automatic do_reset();
      reset = 1;
      @(posedge clk);
      #1;
      reset = 0;
      model_clear();
   endtask

   // Inputs are already applied; check this cycle against the model, then advance one clock.
   task automatic step();
      logic [3:0]  e_stall, e_ack, n_pend, n_line;
      logic [2:0]  e_flush, e_src;
      logic        e_bpu, trap_req, n_wait, n_trap, n_ret;
      logic [4:0]  n_code;
      logic [31:0] n_epc;
      int          n_bub;
      #1;
      trap_req = exmem_syscall || (int_enable && m_pend != 0);
      e_stall = 0; e_flush = 0; e_src = 0; e_bpu = 0;
      n_wait = m_wait; n_trap = 0; n_ret = 0; n_bub = m_bub;
      n_code = m_code; n_epc = m_epc; n_line = m_line;
      e_ack = m_trap ? m_line : 4'h0;
      if (m_trap) begin
         e_src = 3; e_flush = 3'b111; n_bub = 0;
      end else if (m_ret) begin
         e_src = 4; e_flush = 3'b111; n_bub = 0;
      end else if (m_wait) begin
         e_stall = 4'b1111;
         if (!mem_stall) begin n_wait = 0; n_trap = 1; end
      end else begin
         e_bpu = exmem_branch_valid && !mem_stall && !trap_req && !exmem_eret;
         if (trap_req) begin
            e_stall = 4'b1111;
            n_code = exmem_syscall ? 5'd8 : 5'd0;
            n_epc = exmem_pc;
            n_line = exmem_syscall ? 4'h0 : lowest(m_pend);
            if (mem_stall) n_wait = 1; else n_trap = 1;
         end else if (mem_stall) begin
            e_stall = 4'b1111;
         end else if (exmem_eret) begin
            e_stall = 4'b1111; n_ret = 1;
         end else if (exmem_branch_valid && predicted_idex_pc != target_exmem_pc) begin
            e_src = 2; e_flush = 3'b110; n_bub = 0;
         end else if (id_jump) begin
            e_src = 1; e_flush = 3'b100;
         end else if (m_bub > 0) begin
            e_stall = 4'b1100; e_flush = 3'b010; n_bub = m_bub - 1;
         end else if (idex_mem_read && idex_rd_addr != 0 &&
                      (idex_rd_addr == ifid_rs_addr || idex_rd_addr == ifid_rt_addr)) begin
            e_stall = 4'b1100; e_flush = 3'b010; n_bub = LOAD_LAT - 1;
         end
      end
      n_pend = (m_pend | (irq & irq_mask)) & ~e_ack;

      check_eq("pc_src", 64'(cu_pc_src), 64'(e_src));
      check_eq("stall", 64'({cu_pc_stall, cu_ifid_stall, cu_idex_stall, cu_exmem_stall}), 64'(e_stall));
      check_eq("flush", 64'({cu_ifid_flush, cu_idex_flush, cu_exmem_flush}), 64'(e_flush));
      check_eq("bpu_write_en", 64'(bpu_write_en), 64'(e_bpu));
      check_eq("busy", 64'(cu_busy), 64'(m_wait | m_trap | m_ret));
      check_eq("cp0_w_en", 64'(cu_cp0_w_en), 64'(m_trap));
      check_eq("irq_ack", 64'(cu_irq_ack), 64'(e_ack));
      check_eq("vector", 64'(cu_vector), 64'(m_ret ? cp0_epc : EXC_VEC));
      if (m_trap) begin
         check_eq("exec_code", 64'(cu_exec_code), 64'(m_code));
         check_eq("epc", 64'(cu_epc), 64'(m_epc));
      end

      @(posedge clk);
      m_wait = n_wait; m_trap = n_trap; m_ret = n_ret; m_bub = n_bub;
      m_code = n_code; m_epc = n_epc; m_line = n_line; m_pend = n_pend;
      #1;
   endtask

   initial begin
      clear_inputs();
      model_clear();
      reset = 1;
      repeat (2) @(posedge clk);
      #1;
      check_eq("reset_busy", 64'(cu_busy), 64'd0);
      check_eq("reset_cp0", 64'(cu_cp0_w_en), 64'd0);
      check_eq("reset_src", 64'(cu_pc_src), 64'd0);
      check_eq("reset_ack", 64'(cu_irq_ack), 64'd0);
      check_eq("reset_vector", 64'(cu_vector), 64'(EXC_VEC));
      check_eq("reset_epc", 64'(cu_epc), 64'd0);
      reset = 0;
      step();

      // load-use, two bubbles
      idex_mem_read = 1; idex_rd_addr = 5; ifid_rs_addr = 5;
      #1 check_eq("lu_stall1", 64'({cu_pc_stall, cu_ifid_stall, cu_idex_flush}), 64'b111);
      step();
      idex_mem_read = 0;
      #1 check_eq("lu_stall2", 64'({cu_pc_stall, cu_ifid_stall, cu_idex_flush}), 64'b111);
      step();
      #1 check_eq("lu_done", 64'({cu_pc_stall, cu_ifid_stall, cu_idex_flush}), 64'b000);
      step();

      // mispredict beats load-use
      idex_mem_read = 1; idex_rd_addr = 5; ifid_rs_addr = 5;
      exmem_branch_valid = 1; predicted_idex_pc = 32'h0040_0010; target_exmem_pc = 32'h0040_0100;
      #1 check_eq("mp_src", 64'(cu_pc_src), 64'd2);
      check_eq("mp_pc_stall", 64'(cu_pc_stall), 64'd0);
      check_eq("mp_flush", 64'({cu_ifid_flush, cu_idex_flush}), 64'b11);
      check_eq("mp_bpu", 64'(bpu_write_en), 64'd1);
      step();
      clear_inputs();

      // syscall
      exmem_syscall = 1; exmem_pc = 32'h0040_0020;
      step();
      exmem_syscall = 0;
      #1 check_eq("sys_cp0", 64'(cu_cp0_w_en), 64'd1);
      check_eq("sys_code", 64'(cu_exec_code), 64'd8);
      check_eq("sys_epc", 64'(cu_epc), 64'h0040_0020);
      check_eq("sys_src", 64'(cu_pc_src), 64'd3);
      step();

      // interrupt under three cycles of memory stall
      irq = 4'b0110; irq_mask = 4'b1111; int_enable = 1;
      step();
      irq = 0; mem_stall = 1; exmem_pc = 32'h0040_0030;
      step();
      for (int i = 0; i < 3; i++) begin
         if (i == 2) mem_stall = 0;
         #1 check_eq("drain_busy", 64'(cu_busy), 64'd1);
         check_eq("drain_cp0", 64'(cu_cp0_w_en), 64'd0);
         step();
      end
      #1 check_eq("irq_code", 64'(cu_exec_code), 64'd0);
      check_eq("irq_ack1", 64'(cu_irq_ack), 64'b0010);
      step();
      #1 check_eq("irq2_pending", 64'(cu_pc_stall), 64'd1);
      step();
      #1 check_eq("irq_ack2", 64'(cu_irq_ack), 64'b0100);
      step();
      clear_inputs();

      // eret
      exmem_eret = 1; cp0_epc = 32'h0040_0024;
      step();
      exmem_eret = 0;
      #1 check_eq("eret_src", 64'(cu_pc_src), 64'd4);
      check_eq("eret_busy", 64'(cu_busy), 64'd1);
      step();
      #1 check_eq("eret_busy_after", 64'(cu_busy), 64'd0);
      step();

      // reset while draining
      irq = 4'b0001; irq_mask = 4'b0001; int_enable = 1;
      step();
      irq = 0; mem_stall = 1;
      step();
      #1 check_eq("pre_reset_busy", 64'(cu_busy), 64'd1);
      mem_stall = 0;
      do_reset();
      check_eq("rst_drain_busy", 64'(cu_busy), 64'd0);
      check_eq("rst_drain_cp0", 64'(cu_cp0_w_en), 64'd0);
      check_eq("rst_pend_clear", 64'(cu_pc_stall), 64'd0);
      step();
      step();

      // randomized traffic
      for (int c = 0; c < 4000; c++) begin
         mem_stall          = ($urandom_range(0, 9) < 2);
         ifid_rs_addr       = 5'($urandom_range(0, 3));
         ifid_rt_addr       = 5'($urandom_range(0, 3));
         idex_rd_addr       = 5'($urandom_range(0, 3));
         idex_mem_read      = ($urandom_range(0, 9) < 3);
         exmem_branch_valid = ($urandom_range(0, 4) == 0);
         predicted_idex_pc  = 32'h0040_0100 + 32'($urandom_range(0, 1)) * 4;
         target_exmem_pc    = 32'h0040_0100 + 32'($urandom_range(0, 1)) * 4;
         exmem_pc           = $urandom;
         cp0_epc            = $urandom;
         id_jump            = ($urandom_range(0, 7) == 0);
         exmem_syscall      = ($urandom_range(0, 39) == 0);
         exmem_eret         = ($urandom_range(0, 39) == 0);
         irq                = ($urandom_range(0, 14) == 0) ? 4'($urandom_range(1, 15)) : 4'h0;
         irq_mask           = 4'($urandom_range(0, 15));
         int_enable         = ($urandom_range(0, 3) != 0);
         step();
      end

      $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
      $finish;
   end

endmodule
